// File: rtl/fe_icache_resp_if.sv
// Fetch-to-I$ port: request channel from fetch and response channel back to fetch.
// master = fetch side, slave = cache/responder side.
interface fe_icache_resp_if;
  logic        req_valid;
  logic [63:0] req_pc;
  logic        req_ready;

  logic        rsp_valid;
  logic [63:0] rsp_pc;
  logic [31:0] rsp_inst;
  logic        rsp_fault;
  logic        rsp_ready;

  modport master (
    output req_valid, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_pc, rsp_inst, rsp_fault
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_pc, rsp_inst, rsp_fault
  );
endinterface

// File: rtl/fe_icache_resp.sv
// Responder end of the fetch I-cache port. Requests are checked for alignment
// and range, good ones read a 1-cycle synchronous instruction RAM, and every
// request (faulted or not) produces exactly one in-order response. A single
// stage register holds the request while its RAM read is in flight; the
// response FIFO behind it absorbs backpressure. A credit on stage + FIFO
// occupancy keeps the FIFO from ever overflowing.
module fe_icache_resp #(
  parameter int          DEPTH   = 2,
  parameter int          MEM_AW  = 14,
  parameter logic [63:0] PC_BASE = 64'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  fe_icache_resp_if.slave     ic,
  output logic                mem_rd_en,
  output logic [MEM_AW-1:0]   mem_rd_addr,
  input  logic [31:0]         mem_rd_data
);

  // Pointer width stays at least one bit so DEPTH=1 still elaborates.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_OC = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // Request-side decode.
  logic [64:0]       off_ext;
  logic [63:0]       off;
  logic              below_base;
  logic              fault;
  logic              unused_off_lsb;

  // Credit and handshakes.
  logic [CW:0]       occ;
  logic              req_ready;
  logic              req_fire;
  logic              rsp_valid;
  logic              push;
  logic              pop;

  // Stage register: request whose RAM read is in flight.
  logic              stage_valid;
  logic [63:0]       stage_pc;
  logic              stage_fault;

  // Response FIFO.
  logic [63:0]       fifo_pc    [DEPTH];
  logic [31:0]       fifo_inst  [DEPTH];
  logic              fifo_fault [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;

  // Circular increment that also works for non-power-of-2 depths.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // The extra top bit of the subtraction is the borrow, i.e. pc < PC_BASE.
  assign off_ext        = {1'b0, ic.req_pc} - {1'b0, PC_BASE};
  assign off            = off_ext[63:0];
  assign below_base     = off_ext[64];
  assign unused_off_lsb = ^off[1:0];

  // Fault classification of the incoming PC: misaligned, below the window, or past the end of RAM.
  always_comb begin
    fault = 1'b0;
    if (ic.req_pc[1:0] != 2'b00) fault = 1'b1;
    if (below_base)              fault = 1'b1;
    if (off[63:MEM_AW+2] != '0)  fault = 1'b1;
  end

  assign occ       = {1'b0, fifo_count} + (CW + 1)'(stage_valid);
  assign req_ready = !rst && !flush && (occ < DEPTH_OC);
  assign req_fire  = ic.req_valid && req_ready;

  assign ic.req_ready = req_ready;

  // Faulted requests never touch the RAM; the address is held at zero in reset.
  assign mem_rd_en   = req_fire && !fault;
  assign mem_rd_addr = rst ? '0 : off[MEM_AW+1:2];

  assign rsp_valid = (fifo_count != '0);
  assign push      = stage_valid && !flush;
  assign pop       = rsp_valid && ic.rsp_ready && !flush;

  assign ic.rsp_valid = rsp_valid;
  assign ic.rsp_pc    = fifo_pc[rd_ptr];
  assign ic.rsp_inst  = fifo_inst[rd_ptr];
  assign ic.rsp_fault = fifo_fault[rd_ptr];

  // Stage register captures an accepted request for exactly one cycle while RAM data arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_pc    <= '0;
      stage_fault <= 1'b0;
    end else if (flush) begin
      stage_valid <= 1'b0;
    end else begin
      stage_valid <= req_fire;
      if (req_fire) begin
        stage_pc    <= ic.req_pc;
        stage_fault <= fault;
      end
    end
  end

  // FIFO storage: the staged request is written together with the RAM word that just returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_inst[i]  <= '0;
        fifo_fault[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_pc[wr_ptr]    <= stage_pc;
      fifo_inst[wr_ptr]  <= stage_fault ? 32'h0 : mem_rd_data;
      fifo_fault[wr_ptr] <= stage_fault;
    end
  end

  // FIFO pointers and count; flush empties the queue without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CW'(1);
    end
  end

  // The occupancy credit must make a push into a full FIFO impossible.
  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == DEPTH_C)));

endmodule

// File: tb/tb_fe_icache_resp.sv
// Testbench for fe_icache_resp: directed vector table, hand-written reset and
// redirect sequences, and randomized traffic, all checked against a
// transaction-level reference model (queue of outstanding requests).
module tb_fe_icache_resp;
  localparam int          DEPTH   = 2;
  localparam int          MEM_AW  = 8;
  localparam logic [63:0] PC_BASE = 64'h100;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;

  fe_icache_resp_if ic();

  fe_icache_resp #(.DEPTH(DEPTH), .MEM_AW(MEM_AW), .PC_BASE(PC_BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .ic          (ic),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Instruction RAM: synchronous read, data one cycle after the strobe.
  logic [31:0] ram [2**MEM_AW];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
    int          cyc;
  } exp_t;

  typedef struct {
    logic              flush;
    logic              v;
    logic [63:0]       pc;
    logic              rr;
    logic              e_ready;
    logic              e_en;
    logic [MEM_AW-1:0] e_addr;
    logic              e_rv;
    logic [63:0]       e_pc;
    logic [31:0]       e_inst;
    logic              e_fault;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic logic ref_fault(input logic [63:0] pc);
    logic [63:0] o;
    o = pc - PC_BASE;
    return (pc % 4 != 0) || (pc < PC_BASE) || ((o >> (MEM_AW + 2)) != 0);
  endfunction

  function automatic logic [31:0] ref_inst(input logic [63:0] pc);
    logic [63:0] w;
    w = (pc - PC_BASE) >> 2;
    return ref_fault(pc) ? 32'h0 : ram[w[MEM_AW-1:0]];
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic [63:0] pc, input logic rr);
    rst          = r;
    flush        = f;
    ic.req_valid = v;
    ic.req_pc    = pc;
    ic.rsp_ready = rr;
  endtask

  function automatic logic model_ready();
    return !rst && !flush && (exp_q.size() < DEPTH);
  endfunction

  function automatic logic model_rsp_valid();
    return !rst && (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
  endfunction

  // Compare every DUT output against the reference model for the current cycle.
  task automatic checkOutput();
    logic e_ready, e_en, e_rv;
    logic [63:0] w;
    e_ready = model_ready();
    e_en    = e_ready && ic.req_valid && !ref_fault(ic.req_pc);
    e_rv    = model_rsp_valid();
    checkValue("req_ready", ic.req_ready, e_ready);
    checkValue("mem_rd_en", mem_rd_en, e_en);
    if (e_en) begin
      w = (ic.req_pc - PC_BASE) >> 2;
      checkValue("mem_rd_addr", mem_rd_addr, w[MEM_AW-1:0]);
    end
    checkValue("rsp_valid", ic.rsp_valid, e_rv);
    if (e_rv) begin
      checkValue("rsp_pc", ic.rsp_pc, exp_q[0].pc);
      checkValue("rsp_inst", ic.rsp_inst, exp_q[0].inst);
      checkValue("rsp_fault", ic.rsp_fault, exp_q[0].fault);
    end
    if (rst) begin
      checkValue("rst_rsp_pc", ic.rsp_pc, 64'h0);
      checkValue("rst_rsp_inst", ic.rsp_inst, 64'h0);
      checkValue("rst_rsp_fault", ic.rsp_fault, 64'h0);
      checkValue("rst_mem_rd_addr", mem_rd_addr, 64'h0);
    end
  endtask

  // Advance the reference model across the coming clock edge.
  task automatic advanceModel();
    exp_t e;
    logic fire, rv;
    fire = model_ready() && ic.req_valid;
    rv   = model_rsp_valid();
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (rv && ic.rsp_ready) void'(exp_q.pop_front());
      if (fire) begin
        e.pc    = ic.req_pc;
        e.inst  = ref_inst(ic.req_pc);
        e.fault = ref_fault(ic.req_pc);
        e.cyc   = cyc;
        exp_q.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic stepCycle();
    #1;
    checkOutput();
    advanceModel();
    @(negedge clk);
  endtask

  task automatic addVec(input logic f, input logic v, input logic [63:0] pc, input logic rr,
                        input logic er, input logic een, input logic [MEM_AW-1:0] ea,
                        input logic erv, input logic [63:0] epc, input logic [31:0] ei,
                        input logic ef);
    vec_t t;
    t.flush = f; t.v = v; t.pc = pc; t.rr = rr;
    t.e_ready = er; t.e_en = een; t.e_addr = ea;
    t.e_rv = erv; t.e_pc = epc; t.e_inst = ei; t.e_fault = ef;
    tbl.push_back(t);
  endtask

  initial begin
    logic [63:0] next_pc;
    logic        fired;
    logic        seen_redirect;
    logic        r, f, v, rr;
    logic [63:0] pc;

    for (int i = 0; i < 2**MEM_AW; i++) ram[i] = 32'hC0DE_0000 | i;

    // Hand-computed cycle vectors: latency, faults, backpressure, flush.
    //     flush v  pc        rr  ready en addr   rv pc        inst          fault
    addVec(0,   1, 64'h100,  1,  1,    1, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 1, 64'h100,  32'hC0DE0000, 0);
    addVec(0,   1, 64'h102,  1,  1,    0, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   1, 64'h500,  1,  1,    0, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   1, 64'h4FC,  1,  0,    0, 8'h00, 1, 64'h102,  32'h0,        1);
    addVec(0,   1, 64'h4FC,  1,  1,    1, 8'hFF, 1, 64'h500,  32'h0,        1);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 1, 64'h4FC,  32'hC0DE00FF, 0);
    addVec(0,   1, 64'hFC,   1,  1,    0, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 1, 64'hFC,   32'h0,        1);
    addVec(0,   1, 64'h100,  0,  1,    1, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   1, 64'h104,  0,  1,    1, 8'h01, 0, 64'h0,    32'h0,        0);
    addVec(0,   1, 64'h108,  0,  0,    0, 8'h00, 1, 64'h100,  32'hC0DE0000, 0);
    addVec(0,   1, 64'h108,  0,  0,    0, 8'h00, 1, 64'h100,  32'hC0DE0000, 0);
    addVec(0,   1, 64'h108,  1,  0,    0, 8'h00, 1, 64'h100,  32'hC0DE0000, 0);
    addVec(0,   1, 64'h108,  1,  1,    1, 8'h02, 1, 64'h104,  32'hC0DE0001, 0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 1, 64'h108,  32'hC0DE0002, 0);
    addVec(0,   1, 64'h100,  0,  1,    1, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   1, 64'h104,  0,  1,    1, 8'h01, 0, 64'h0,    32'h0,        0);
    addVec(0,   0, 64'h0,    0,  0,    0, 8'h00, 1, 64'h100,  32'hC0DE0000, 0);
    addVec(1,   1, 64'h108,  0,  0,    0, 8'h00, 1, 64'h100,  32'hC0DE0000, 0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   1, 64'h110,  1,  1,    1, 8'h04, 0, 64'h0,    32'h0,        0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 0, 64'h0,    32'h0,        0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 1, 64'h110,  32'hC0DE0004, 0);
    addVec(0,   0, 64'h0,    1,  1,    0, 8'h00, 0, 64'h0,    32'h0,        0);

    // Reset state.
    applyStimulus(1, 0, 0, 64'h0, 0);
    stepCycle();
    stepCycle();

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(0, tbl[i].flush, tbl[i].v, tbl[i].pc, tbl[i].rr);
      #1;
      checkValue($sformatf("tbl%0d_ready", i), ic.req_ready, tbl[i].e_ready);
      checkValue($sformatf("tbl%0d_rd_en", i), mem_rd_en, tbl[i].e_en);
      if (tbl[i].e_en) checkValue($sformatf("tbl%0d_addr", i), mem_rd_addr, tbl[i].e_addr);
      checkValue($sformatf("tbl%0d_rsp_valid", i), ic.rsp_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) begin
        checkValue($sformatf("tbl%0d_rsp_pc", i), ic.rsp_pc, tbl[i].e_pc);
        checkValue($sformatf("tbl%0d_rsp_inst", i), ic.rsp_inst, tbl[i].e_inst);
        checkValue($sformatf("tbl%0d_rsp_fault", i), ic.rsp_fault, tbl[i].e_fault);
      end
      stepCycle();
    end

    // Reset with one staged and one buffered request: nothing stale may surface.
    applyStimulus(0, 0, 1, 64'h100, 0);
    stepCycle();
    applyStimulus(0, 0, 1, 64'h104, 0);
    stepCycle();
    applyStimulus(1, 0, 1, 64'h108, 1);
    #1;
    checkValue("midrst_rsp_valid", ic.rsp_valid, 1'b0);
    checkValue("midrst_req_ready", ic.req_ready, 1'b0);
    stepCycle();
    applyStimulus(0, 0, 0, 64'h0, 1);
    #1;
    checkValue("postrst_req_ready", ic.req_ready, 1'b1);
    for (int i = 0; i < 6; i++) stepCycle();

    // Sequential fetch stream with a redirect to 0x140 part way through.
    next_pc = PC_BASE;
    seen_redirect = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) next_pc = 64'h140;
      applyStimulus(0, (k == 20), 1, next_pc, ($urandom_range(0, 3) != 0));
      #1;
      fired = ic.req_valid && ic.req_ready;
      if (k > 20 && !seen_redirect && ic.rsp_valid && ic.rsp_ready) begin
        checkValue("redirect_first_pc", ic.rsp_pc, 64'h140);
        seen_redirect = 1'b1;
      end
      stepCycle();
      if (fired) next_pc = next_pc + 64'd4;
    end
    checkValue("redirect_seen", seen_redirect, 1'b1);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0:       pc = PC_BASE + 64'($urandom_range(0, 255) * 4) + 64'($urandom_range(1, 3));
        1:       pc = 64'($urandom_range(0, 63) * 4);
        2:       pc = PC_BASE + 64'h400 + 64'($urandom_range(0, 1023) * 4);
        default: pc = PC_BASE + 64'($urandom_range(0, 255) * 4);
      endcase
      applyStimulus(r, f, v, pc, rr);
      stepCycle();
    end

    applyStimulus(0, 0, 0, 64'h0, 1);
    for (int i = 0; i < 4; i++) stepCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
